// File: rtl/switch_pkg.sv
// Shared types and sizes for the 4x4 crossbar control path.
package switch_pkg;
    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } out_state_e;
endpackage

// File: rtl/crossbar_scheduler_if.sv
// Request/grant bundle between the input buffers, the scheduler and the crossbar mux selects.
interface crossbar_scheduler_if;
    import switch_pkg::*;

    // req[i] is a level request for output dest<i>. grant[i] is the acceptance
    // and stays high for the whole packet until last[i] is sampled while it is
    // high. Unlike valid/ready, a requester may drop req before grant with no
    // effect, and grant is never combinational from req.
    logic [NUM_PORTS-1:0] req;
    port_idx_t            dest0;
    port_idx_t            dest1;
    port_idx_t            dest2;
    port_idx_t            dest3;
    logic [NUM_PORTS-1:0] last;
    logic [NUM_PORTS-1:0] grant;
    port_idx_t            sel0;
    port_idx_t            sel1;
    port_idx_t            sel2;
    port_idx_t            sel3;
    logic [NUM_PORTS-1:0] busy;

    modport master (
        output req, dest0, dest1, dest2, dest3, last,
        input  grant, sel0, sel1, sel2, sel3, busy
    );

    modport slave (
        input  req, dest0, dest1, dest2, dest3, last,
        output grant, sel0, sel1, sel2, sel3, busy
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter4
    import switch_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_vec,
    input  port_idx_t            ptr,
    output logic                 valid,
    output port_idx_t            winner
);
    port_idx_t idx;

    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr + port_idx_t'(k);
            if (!valid && req_vec[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/crossbar_scheduler.sv
// Per-output ownership scheduler: each output arbitrates round-robin while idle and
// stays owned by one input until that input's end-of-packet.
module crossbar_scheduler
    import switch_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset_n,
    crossbar_scheduler_if.slave         bus,
    output logic [NUM_PORTS-1:0]        dbg_state,
    output logic [NUM_PORTS*PORT_W-1:0] dbg_ptr
);
    port_idx_t            dest [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand [NUM_PORTS];
    logic [NUM_PORTS-1:0] win_valid;
    port_idx_t            win_idx [NUM_PORTS];

    out_state_e state_q [NUM_PORTS];
    out_state_e state_d [NUM_PORTS];
    port_idx_t  owner_q [NUM_PORTS];
    port_idx_t  owner_d [NUM_PORTS];
    port_idx_t  ptr_q   [NUM_PORTS];
    port_idx_t  ptr_d   [NUM_PORTS];

    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] busy;

    assign dest[0] = bus.dest0;
    assign dest[1] = bus.dest1;
    assign dest[2] = bus.dest2;
    assign dest[3] = bus.dest3;

    // An input already holding a grant never competes again until it releases.
    always_comb begin
        cand = '{default: '0};
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[o][i] = bus.req[i] && (dest[i] == port_idx_t'(o)) && !grant[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
        rr_arbiter4 u_arb (
            .req_vec (cand[g]),
            .ptr     (ptr_q[g]),
            .valid   (win_valid[g]),
            .winner  (win_idx[g])
        );
    end

    // Release goes straight to IDLE without arbitrating, leaving a one-cycle bubble.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            case (state_q[o])
                IDLE: begin
                    if (win_valid[o]) begin
                        state_d[o] = BUSY;
                        owner_d[o] = win_idx[o];
                        ptr_d[o]   = win_idx[o] + 2'd1;
                    end
                end
                BUSY: begin
                    if (bus.last[owner_q[o]]) begin
                        state_d[o] = IDLE;
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    always_comb begin
        busy      = '0;
        grant     = '0;
        dbg_state = '0;
        dbg_ptr   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            busy[o]                 = (state_q[o] == BUSY);
            dbg_state[o]            = (state_q[o] == BUSY);
            dbg_ptr[o*PORT_W +: PORT_W] = ptr_q[o];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (busy[o] && (owner_q[o] == port_idx_t'(i))) begin
                    grant[i] = 1'b1;
                end
            end
        end
    end

    assign bus.grant = grant;
    assign bus.busy  = busy;
    assign bus.sel0  = owner_q[0];
    assign bus.sel1  = owner_q[1];
    assign bus.sel2  = owner_q[2];
    assign bus.sel3  = owner_q[3];
endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed scenarios for crossbar_scheduler; expectations queued per cycle and
// checked by an independent monitor shortly after each rising edge.
module tb_crossbar_scheduler;
    import switch_pkg::*;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] dbg_state;
    logic [7:0] dbg_ptr;

    crossbar_scheduler_if bus ();

    crossbar_scheduler dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Word layout: {grant[3:0], busy[3:0], sel3,sel2,sel1,sel0, ptr3,ptr2,ptr1,ptr0}
    logic [23:0] exp_q [$];
    logic [23:0] msk_q [$];
    int          tag_q [$];
    string       name_q [$];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    function automatic logic [23:0] act_word();
        return {bus.grant, bus.busy, bus.sel3, bus.sel2, bus.sel1, bus.sel0, dbg_ptr};
    endfunction

    task automatic compare(string nm, logic [23:0] exp, logic [23:0] msk);
        logic [23:0] act;
        act = act_word();
        chk_cnt++;
        if ((act & msk) == (exp & msk)) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got g=%b b=%b sel=%h ptr=%h, want g=%b b=%b sel=%h ptr=%h (sel mask %h)",
                     nm, act[23:20], act[19:16], act[15:8] & msk[15:8], act[7:0],
                     exp[23:20], exp[19:16], exp[15:8] & msk[15:8], exp[7:0], msk[15:8]);
        end
    endtask

    // sel fields are only meaningful for busy outputs, so they are masked otherwise.
    task automatic expect_nxt(string nm, logic [3:0] g, logic [3:0] b, logic [7:0] sel, logic [7:0] ptr);
        logic [7:0] sm;
        sm = '0;
        for (int o = 0; o < 4; o++) if (b[o]) sm[o*2 +: 2] = 2'b11;
        exp_q.push_back({g, b, sel, ptr});
        msk_q.push_back({8'hFF, sm, 8'hFF});
        tag_q.push_back(cyc + 1);
        name_q.push_back(nm);
    endtask

    always @(posedge clock) begin
        #2;
        while (tag_q.size() > 0 && tag_q[0] <= cyc) begin
            void'(tag_q.pop_front());
            compare(name_q.pop_front(), exp_q.pop_front(), msk_q.pop_front());
        end
    end

    task automatic drive(logic [3:0] r, logic [7:0] dv, logic [3:0] l);
        @(negedge clock);
        bus.req   = r;
        bus.dest0 = dv[1:0];
        bus.dest1 = dv[3:2];
        bus.dest2 = dv[5:4];
        bus.dest3 = dv[7:6];
        bus.last  = l;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n  = 1'b0;
        bus.req  = '0;
        bus.last = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    logic [3:0] t3_g  [8] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
    logic [1:0] t3_s0 [8] = '{2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0};
    logic [1:0] t3_p0 [8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [3:0] t4_g  [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    logic [1:0] t4_s1 [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
    logic [1:0] t4_p1 [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};

    initial begin
        bus.req   = '0;
        bus.last  = '0;
        bus.dest0 = '0;
        bus.dest1 = '0;
        bus.dest2 = '0;
        bus.dest3 = '0;

        // single request, release, and last while ungranted
        apply_reset();
        drive(4'b0000, 8'h00, 4'b0000);
        expect_nxt("reset_idle", 4'b0000, 4'b0000, 8'h00, 8'h00);
        drive(4'b0001, 8'b00_00_00_10, 4'b0000);
        expect_nxt("single_grant", 4'b0001, 4'b0100, 8'h00, 8'b00_01_00_00);
        drive(4'b0001, 8'b00_00_00_10, 4'b0001);
        expect_nxt("single_release", 4'b0000, 4'b0000, 8'h00, 8'b00_01_00_00);
        drive(4'b0000, 8'b00_00_00_10, 4'b0001);
        expect_nxt("last_ungranted", 4'b0000, 4'b0000, 8'h00, 8'b00_01_00_00);

        // disjoint destinations: all four granted together
        apply_reset();
        drive(4'b1111, 8'b00_01_10_11, 4'b0000);
        expect_nxt("disjoint_grant", 4'b1111, 4'b1111, 8'b00_01_10_11, 8'b01_10_11_00);
        drive(4'b0000, 8'b00_01_10_11, 4'b1111);
        expect_nxt("disjoint_release", 4'b0000, 4'b0000, 8'h00, 8'b01_10_11_00);

        // inputs 1 and 3 fight for output 0 with one-word packets
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'b1010, 8'h00, 4'b1010);
            expect_nxt($sformatf("pair_fair_%0d", k), t3_g[k],
                       (t3_g[k] != 0) ? 4'b0001 : 4'b0000,
                       {6'b0, t3_s0[k]}, {6'b0, t3_p0[k]});
        end

        // everyone targets output 1
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 8'b01_01_01_01, 4'b1111);
            expect_nxt($sformatf("quad_fair_%0d", k), t4_g[k],
                       (t4_g[k] != 0) ? 4'b0010 : 4'b0000,
                       {4'b0, t4_s1[k], 2'b0}, {4'b0, t4_p1[k], 2'b0});
        end

        // ownership: req drop, dest change and foreign last do not disturb the owner
        apply_reset();
        drive(4'b0100, 8'b00_11_00_00, 4'b0000);
        expect_nxt("own_grant", 4'b0100, 4'b1000, 8'b10_00_00_00, 8'b11_00_00_00);
        drive(4'b0000, 8'b00_00_00_00, 4'b0001);
        expect_nxt("own_req_drop", 4'b0100, 4'b1000, 8'b10_00_00_00, 8'b11_00_00_00);
        drive(4'b0100, 8'b00_01_00_00, 4'b1011);
        expect_nxt("own_dest_change", 4'b0100, 4'b1000, 8'b10_00_00_00, 8'b11_00_00_00);
        drive(4'b0000, 8'b00_01_00_00, 4'b0100);
        expect_nxt("own_release", 4'b0000, 4'b0000, 8'h00, 8'b11_00_00_00);

        // asynchronous reset with outputs 0, 1 and 3 owned
        apply_reset();
        drive(4'b0111, 8'b00_11_01_00, 4'b0000);
        expect_nxt("pre_reset_busy", 4'b0111, 4'b1011, 8'b10_00_01_00, 8'b11_00_10_01);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        compare("async_reset", 24'h000000, 24'hFFFFFF);
        bus.req  = '0;
        bus.last = '0;
        @(negedge clock);
        reset_n = 1'b1;
        drive(4'b1001, 8'b11_00_00_11, 4'b0000);
        expect_nxt("ptr_restart", 4'b0001, 4'b1000, 8'h00, 8'b01_00_00_00);

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
            chk_cnt += exp_q.size();
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        chk_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/crossbar_scheduler.md
# crossbar_scheduler

- Round-robin scheduler for the 4x4 packet crossbar.
- Each input port requests one output port. The block resolves destination conflicts by granting each output to at most one input at a time.
- A grant holds until the owning input signals end of packet.
- Sits between the input port buffers and the crossbar mux select lines. It replaces the one-shot pairwise destination-conflict check with per-output ownership that persists across cycles.

## Interface
Parameters:
- NUM_PORTS, 4, number of input and output ports. Only 4 is supported.
- PORT_W, 2, width of a port index.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  4  req[i] high means input i holds a packet wanting output dest_i.
- dest0..dest3  in  2 each  destination output of input 0..3. Sampled only while that input's req is high and it is not yet granted.
- last  in  4  last[i] high marks the final word of input i's packet. Honored only while grant[i] is high.
- grant  out  4  grant[i] high means input i owns its destination output and may drive data.
- sel0..sel3  out  2 each  index of the input currently driving output 0..3. Meaningful only when busy[o] is high.
- busy  out  4  busy[o] high means output o is owned.

## Operation
Per-output state machine, states IDLE and BUSY, plus:
- owner[o], 2 bits
- round-robin pointer ptr[o], 2 bits

IDLE behaviour:
- Candidates are inputs i with req[i]=1, dest_i=o and grant[i]=0.
- Search starts at ptr[o] and proceeds ptr[o], ptr[o]+1 mod 4, and so on. The first candidate found wins.
- On a win, at the next edge: state goes to BUSY, owner[o] takes the winner, ptr[o] takes winner+1 mod 4, and grant[winner] is set.
- With no candidate, state and ptr are unchanged.

BUSY behaviour:
- When last[owner[o]]=1 is seen, at the next edge: state goes to IDLE and grant[owner] clears.
- No arbitration for o happens in the cycle its release is sampled. This produces a one-cycle bubble, which is intended.
- req and dest of the owner are ignored while BUSY. Dropping req does not release ownership; only last does.

Requests that are not granted:
- A non-granted input may drop req at any time with no effect on state.
- It may change dest_i between cycles; the new value is arbitrated.

Each input targets one output, so it holds at most one grant. Arbitration for different outputs is fully independent, so up to 4 grants can be issued in the same cycle.

Derived outputs:
- sel[o] equals owner[o].
- busy[o] equals (state[o]==BUSY).
- grant[i] equals OR over o of (busy[o] and owner[o]==i). It is registered, never combinational from req.

## Timing
- Reset values: grant=0000, busy=0000, sel0..sel3=0, every ptr=0, every owner=0, every state IDLE. Reset is asynchronous and takes effect immediately.
- Request to grant: req[i] high in cycle t with the output IDLE and i winning gives grant[i]=1 from cycle t+1.
- Release: last[i] sampled high in cycle t gives grant[i]=0 and busy=0 from t+1. The earliest new grant of that output appears at t+2.
- last[i] asserted while grant[i]=0 is ignored.
- last in the very first granted cycle is legal and gives a 1-cycle ownership.
- Reset asserted mid-packet clears all grants immediately. In-flight packets are abandoned and the input buffers must re-request.
- Losers keep req high and are served in pointer order. Worst-case wait is 3 packet lengths plus 3 bubble cycles.

## Structure
Shared package `switch_pkg` holds:
- NUM_PORTS and PORT_W
- the state enum {IDLE, BUSY}
- the port-index typedef

Sub-module `rr_arbiter4`:
- Purely combinational.
- Inputs: 4-bit request vector and 2-bit pointer.
- Outputs: valid flag and 2-bit winner.
- Instantiated once per output.

`crossbar_scheduler` contains:
- per-output candidate vector decode from req, dest and grant
- the four state/owner/ptr registers
- the grant OR-reduction

## Test plan
- Single request: reset, then req=0001 with dest0=2. Expect grant=0001, busy=0100, sel2=0 at t+1. Pulse last[0], then grant=0000 next cycle.
- Disjoint destinations: dest0..3 = 3,2,1,0, req=1111. All four grants go high together, and sel3=0, sel2=1, sel1=2, sel0=3.
- Two-way conflict with fairness: inputs 1 and 3 both target output 0 with 1-word packets (last held high). Grants alternate 1,3,1,3, each followed by a one-cycle bubble. ptr[0] is checked as 2,0,2,0.
- Four-way conflict: all inputs target output 1 after reset. Grant order is 0,1,2,3. No input is granted twice before all have been served.
- Ownership rules: the owner drops req mid-packet and its grant stays high. The owner changes dest and sel is unchanged. last on a non-owner input is ignored.
- Reset mid-operation: reset_n goes low while busy=1011. grant, busy and sel clear asynchronously before the next edge. After release, the first arbitration starts again from pointer 0.
